// File: rtl/imm_materializer_if.sv
// Request/instruction-stream bundle for imm_materializer.
// The slave side is the materializer; the master side requests constants and consumes instructions.
interface imm_materializer_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_value;
    logic [4:0]  req_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_last;

    modport master (
        output req_valid, req_value, req_rd, out_ready,
        input  req_ready, out_valid, out_inst, out_last
    );

    modport slave (
        input  req_valid, req_value, req_rd, out_ready,
        output req_ready, out_valid, out_inst, out_last
    );
endinterface

// File: rtl/imm_materializer.sv
// Turns a 64-bit constant into the RV64I LUI/ADDI/ADDIW/SLLI sequence that rebuilds it in rd.
// Build option LI_COMPRESS_EN drops zero-immediate ADDI/ADDIW and merges their shifts.
module imm_materializer (
    input  logic              clk,
    input  logic              rst,
    imm_materializer_if.slave bus
);
    localparam logic [6:0]  OP_IMM   = 7'h13;
    localparam logic [6:0]  OP_IMM32 = 7'h1B;
    localparam logic [6:0]  OP_LUI   = 7'h37;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic {IDLE, EMIT} state_t;

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, OP_LUI};
    endfunction

    function automatic logic [31:0] enc_slli(input logic [4:0] rd, input logic [5:0] shamt);
        return {6'b000000, shamt, rd, 3'b001, rd, OP_IMM};
    endfunction

    state_t      state_reg;
    logic        req_ready_reg;
    logic        out_valid_reg;
    logic        out_last_reg;
    logic [31:0] out_inst_reg;
    logic [3:0]  step_reg;
    logic [3:0]  len_reg;
    logic [31:0] seq_reg  [0:7];
    logic [31:0] seq_next [0:7];
    logic [3:0]  len_next;

    logic [63:0] v;
    logic [4:0]  rd;
    logic [31:0] hi;
    logic        fits_s12;
    logic        fits_s32;
    logic        hi_s12;
    logic [19:0] lo_hi20;
    logic [19:0] hi_hi20;
    logic [11:0] chunk    [0:2];
    logic [5:0]  chunk_sh [0:2];
    logic        accept;
`ifdef LI_COMPRESS_EN
    logic [5:0]  pend;
`endif

    assign v        = bus.req_value;
    assign rd       = bus.req_rd;
    assign hi       = v[63:32];
    assign fits_s12 = (v == {{52{v[11]}}, v[11:0]});
    assign fits_s32 = (v == {{32{v[31]}}, v[31:0]});
    assign hi_s12   = (hi == {{20{hi[11]}}, hi[11:0]});
    // The +0x800 rounding compensates for the sign of the following 12-bit add.
    assign lo_hi20  = v[31:12] + {19'd0, v[11]};
    assign hi_hi20  = hi[31:12] + {19'd0, hi[11]};

    // Low word rebuilt in zero-extended chunks so no ADDI ever sign-corrupts the result.
    assign chunk[0]    = {1'b0, v[31:21]};
    assign chunk[1]    = {1'b0, v[20:10]};
    assign chunk[2]    = {2'b00, v[9:0]};
    assign chunk_sh[0] = 6'd11;
    assign chunk_sh[1] = 6'd11;
    assign chunk_sh[2] = 6'd10;

    assign accept = (state_reg == IDLE) && bus.req_valid;

    always_comb begin
        for (int i = 0; i < 8; i++) seq_next[i] = INST_NOP;
        len_next = 4'd0;
`ifdef LI_COMPRESS_EN
        pend = 6'd0;
`endif
        if (rd == 5'd0) begin
            seq_next[0] = INST_NOP;
            len_next    = 4'd1;
        end else if (fits_s12) begin
            seq_next[0] = enc_i(OP_IMM, 3'd0, rd, 5'd0, v[11:0]);
            len_next    = 4'd1;
        end else if (fits_s32) begin
            seq_next[0] = enc_lui(rd, lo_hi20);
            seq_next[1] = enc_i(OP_IMM32, 3'd0, rd, rd, v[11:0]);
            len_next    = 4'd2;
`ifdef LI_COMPRESS_EN
            if (v[11:0] == 12'd0) len_next = 4'd1;
`endif
        end else begin
            if (hi_s12) begin
                seq_next[0] = enc_i(OP_IMM, 3'd0, rd, 5'd0, hi[11:0]);
                len_next    = 4'd1;
            end else begin
                seq_next[0] = enc_lui(rd, hi_hi20);
                seq_next[1] = enc_i(OP_IMM32, 3'd0, rd, rd, hi[11:0]);
                len_next    = 4'd2;
`ifdef LI_COMPRESS_EN
                if (hi[11:0] == 12'd0) len_next = 4'd1;
`endif
            end
            for (int k = 0; k < 3; k++) begin
`ifdef LI_COMPRESS_EN
                pend = pend + chunk_sh[k];
                if (chunk[k] != 12'd0) begin
                    seq_next[len_next[2:0]]        = enc_slli(rd, pend);
                    seq_next[len_next[2:0] + 3'd1] = enc_i(OP_IMM, 3'd0, rd, rd, chunk[k]);
                    len_next = len_next + 4'd2;
                    pend     = 6'd0;
                end
`else
                seq_next[len_next[2:0]]        = enc_slli(rd, chunk_sh[k]);
                seq_next[len_next[2:0] + 3'd1] = enc_i(OP_IMM, 3'd0, rd, rd, chunk[k]);
                len_next = len_next + 4'd2;
`endif
            end
`ifdef LI_COMPRESS_EN
            // Trailing zero chunks still owe their shift; flush it as one SLLI.
            if (pend != 6'd0) begin
                seq_next[len_next[2:0]] = enc_slli(rd, pend);
                len_next = len_next + 4'd1;
            end
`endif
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_seq
            always_ff @(posedge clk) begin
                if (accept) seq_reg[gi] <= seq_next[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b1;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_inst_reg  <= 32'd0;
            step_reg      <= 4'd0;
            len_reg       <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        state_reg     <= EMIT;
                        req_ready_reg <= 1'b0;
                        out_valid_reg <= 1'b1;
                        out_inst_reg  <= seq_next[0];
                        out_last_reg  <= (len_next == 4'd1);
                        step_reg      <= 4'd1;
                        len_reg       <= len_next;
                    end
                end
                EMIT: begin
                    if (out_valid_reg && bus.out_ready) begin
                        if (out_last_reg) begin
                            state_reg     <= IDLE;
                            req_ready_reg <= 1'b1;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            out_inst_reg  <= 32'd0;
                            step_reg      <= 4'd0;
                        end else begin
                            out_inst_reg <= seq_reg[step_reg[2:0]];
                            out_last_reg <= (step_reg == len_reg - 4'd1);
                            step_reg     <= step_reg + 4'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.out_inst  = out_inst_reg;
endmodule

// File: tb/tb_imm_materializer.sv
// Self-checking bench for imm_materializer: directed cases, random constants against an
// arithmetic reference model plus an RV64I executor, stalls, mid-sequence reset, back-to-back.
module tb_imm_materializer;
    logic clk;
    logic rst;
    imm_materializer_if bus ();

    imm_materializer dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];

    function automatic logic [31:0] t_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction
    function automatic logic [31:0] t_addiw(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, rd, 3'b000, rd, 7'h1B};
    endfunction
    function automatic logic [31:0] t_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'h37};
    endfunction
    function automatic logic [31:0] t_slli(input logic [4:0] rd, input logic [5:0] sh);
        return {6'd0, sh, rd, 3'b001, rd, 7'h13};
    endfunction

    task automatic push_s32(input logic [31:0] w, input logic [4:0] rd);
        logic [63:0] t;
        t = {32'd0, w} + 64'h800;
        exp_q.push_back(t_lui(rd, 20'((t >> 12) & 64'hFFFFF)));
`ifdef LI_COMPRESS_EN
        if (w[11:0] != 12'd0) exp_q.push_back(t_addiw(rd, w[11:0]));
`else
        exp_q.push_back(t_addiw(rd, w[11:0]));
`endif
    endtask

    // Reference sequence built from signed-range tests and shift/mask arithmetic.
    task automatic build_expected(input logic [63:0] v, input logic [4:0] rd);
        longint sv;
        longint h;
        logic [63:0] c [3];
        int sh [3];
`ifdef LI_COMPRESS_EN
        int pend;
`endif
        sv = longint'(v);
        exp_q.delete();
        if (rd == 5'd0) begin
            exp_q.push_back(32'h0000_0013);
        end else if (sv >= -2048 && sv <= 2047) begin
            exp_q.push_back(t_addi(rd, 5'd0, v[11:0]));
        end else if (sv >= -64'sd2147483648 && sv <= 64'sd2147483647) begin
            push_s32(v[31:0], rd);
        end else begin
            h = sv >>> 32;
            if (h >= -2048 && h <= 2047) exp_q.push_back(t_addi(rd, 5'd0, 12'(h)));
            else push_s32(32'(h), rd);
            c[0] = (v >> 21) & 64'h7FF;
            c[1] = (v >> 10) & 64'h7FF;
            c[2] = v & 64'h3FF;
            sh = '{11, 11, 10};
`ifdef LI_COMPRESS_EN
            pend = 0;
`endif
            for (int k = 0; k < 3; k++) begin
`ifdef LI_COMPRESS_EN
                pend += sh[k];
                if (c[k] != 64'd0) begin
                    exp_q.push_back(t_slli(rd, 6'(pend)));
                    exp_q.push_back(t_addi(rd, rd, 12'(c[k])));
                    pend = 0;
                end
`else
                exp_q.push_back(t_slli(rd, 6'(sh[k])));
                exp_q.push_back(t_addi(rd, rd, 12'(c[k])));
`endif
            end
`ifdef LI_COMPRESS_EN
            if (pend != 0) exp_q.push_back(t_slli(rd, 6'(pend)));
`endif
        end
    endtask

    // Executes the collected instructions on a tiny RV64I register model.
    function automatic logic [63:0] run_isa(input logic [4:0] rd);
        logic [63:0] x [32];
        logic [31:0] ins;
        logic [63:0] imm;
        logic [63:0] r;
        for (int i = 0; i < 32; i++) x[i] = 64'd0;
        foreach (got_q[i]) begin
            ins = got_q[i];
            imm = {{52{ins[31]}}, ins[31:20]};
            r   = x[ins[19:15]];
            case (ins[6:0])
                7'h13:   r = (ins[14:12] == 3'd1) ? (r << ins[25:20]) : (r + imm);
                7'h1B:   begin r = r + imm; r = {{32{r[31]}}, r[31:0]}; end
                7'h37:   r = {{32{ins[31]}}, ins[31:12], 12'd0};
                default: r = 64'hDEAD_BEEF_DEAD_BEEF;
            endcase
            if (ins[11:7] != 5'd0) x[ins[11:7]] = r;
        end
        return x[rd];
    endfunction

    function automatic int diff_idx();
        if (got_q.size() != exp_q.size()) return (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction
    function automatic logic [31:0] got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : 32'hXXXX_XXXX;
    endfunction
    function automatic logic [31:0] exp_at(input int i);
        return (i < exp_q.size()) ? exp_q[i] : 32'hXXXX_XXXX;
    endfunction

    task automatic do_txn(input logic [63:0] v, input logic [4:0] rd, input int stall_pct,
                          output bit timeout, output bit lat_ok, output bit post_ok,
                          output int bubbles, output int wait_cyc);
        int  cyc;
        bit  done;
        got_q.delete();
        timeout = 0; lat_ok = 0; post_ok = 0; bubbles = 0; wait_cyc = 0;
        while (!bus.req_ready && wait_cyc < 50) begin @(posedge clk); #1; wait_cyc++; end
        if (!bus.req_ready) begin timeout = 1; return; end
        bus.req_valid = 1'b1; bus.req_value = v; bus.req_rd = rd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_value = {$urandom, $urandom}; bus.req_rd = 5'($urandom);
        lat_ok = bus.out_valid;
        done = 0; cyc = 0;
        while (!done && cyc < 200) begin
            bus.out_ready = (int'($urandom_range(99)) >= stall_pct);
            if (bus.out_ready && !bus.out_valid) bubbles++;
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(bus.out_inst);
                done = bus.out_last;
            end
            @(posedge clk); #1; cyc++;
        end
        bus.out_ready = 1'b0;
        timeout = !done;
        post_ok = done && !bus.out_valid && bus.req_ready;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        n_cmp++; if (bus.out_inst !== 32'd0) begin n_bad++; $display("FAIL reset_out_inst: got %h want 00000000", bus.out_inst); end
    endtask

    task automatic test_directed();
        bit to, lat, post; int bub, wc, d;
        logic [63:0] v;
        do_txn(64'h5, 5'd10, 0, to, lat, post, bub, wc);
        $display("txn T1 v=0000000000000005 rd=10 n=%0d", got_q.size());
        n_cmp++; if (lat !== 1'b1) begin n_bad++; $display("FAIL t1_latency: out_valid %b one cycle after accept, want 1", lat); end
        n_cmp++; if (got_q.size() != 1 || got_at(0) !== 32'h00500513) begin n_bad++; $display("FAIL t1_seq: got %0d instrs first %h, want 1 instr 00500513", got_q.size(), got_at(0)); end

        do_txn(64'h7FFFFFFF, 5'd5, 30, to, lat, post, bub, wc);
        $display("txn T2 v=000000007fffffff rd=5 n=%0d", got_q.size());
        n_cmp++; if (got_q.size() != 2 || got_at(0) !== 32'h800002B7 || got_at(1) !== 32'hFFF2829B) begin n_bad++; $display("FAIL t2_seq: got %0d instrs %h %h, want 800002b7 fff2829b", got_q.size(), got_at(0), got_at(1)); end

        v = 64'h0000_0001_0000_0000;
        do_txn(v, 5'd10, 0, to, lat, post, bub, wc);
        $display("txn T3 v=%h rd=10 n=%0d", v, got_q.size());
`ifdef LI_COMPRESS_EN
        n_cmp++; if (got_q.size() != 2 || got_at(0) !== 32'h00100513 || got_at(1) !== 32'h02051513) begin n_bad++; $display("FAIL t3_seq: got %0d instrs %h %h, want 00100513 02051513", got_q.size(), got_at(0), got_at(1)); end
`else
        n_cmp++; if (got_q.size() != 7 || got_at(0) !== 32'h00100513) begin n_bad++; $display("FAIL t3_seq: got %0d instrs first %h, want 7 instrs first 00100513", got_q.size(), got_at(0)); end
`endif
        n_cmp++; if (run_isa(5'd10) !== v) begin n_bad++; $display("FAIL t3_isa: x10 got %h want %h", run_isa(5'd10), v); end

        do_txn(64'hFFFF_FFFF_FFFF_F800, 5'd1, 0, to, lat, post, bub, wc);
        $display("txn T4a v=fffffffffffff800 rd=1 n=%0d", got_q.size());
        n_cmp++; if (got_q.size() != 1 || got_at(0) !== 32'h80000093) begin n_bad++; $display("FAIL t4_min_s12: got %0d instrs first %h, want 1 instr 80000093", got_q.size(), got_at(0)); end

        v = 64'h1234_5678_9ABC_DEF0;
        build_expected(v, 5'd10);
        do_txn(v, 5'd10, 40, to, lat, post, bub, wc);
        $display("txn T4b v=%h rd=10 n=%0d", v, got_q.size());
        d = diff_idx();
        n_cmp++; if (d >= 0) begin n_bad++; $display("FAIL t4_seq: instr %0d got %h want %h (len %0d vs %0d)", d, got_at(d), exp_at(d), got_q.size(), exp_q.size()); end
        n_cmp++; if (run_isa(5'd10) !== v) begin n_bad++; $display("FAIL t4_isa: x10 got %h want %h", run_isa(5'd10), v); end
    endtask

    function automatic logic [63:0] rand_value();
        logic [63:0] v;
        logic [11:0] s12;
        logic [31:0] w;
        case ($urandom_range(4))
            0: begin s12 = 12'($urandom); v = {{52{s12[11]}}, s12}; end
            1: begin w = $urandom; v = {{32{w[31]}}, w}; end
            2: v = {$urandom, $urandom};
            3: begin
                v = {$urandom, $urandom};
                if ($urandom_range(1) == 1) v[31:21] = 11'd0;
                if ($urandom_range(1) == 1) v[20:10] = 11'd0;
                if ($urandom_range(1) == 1) v[9:0]   = 10'd0;
                if ($urandom_range(1) == 1) begin s12 = 12'($urandom); v[63:32] = {{20{s12[11]}}, s12}; end
            end
            default: begin
                case ($urandom_range(7))
                    0: v = 64'h0000_0000_7FFF_F800;
                    1: v = 64'h0000_0000_7FFF_FFFF;
                    2: v = 64'hFFFF_FFFF_8000_0000;
                    3: v = 64'h0000_0000_8000_0000;
                    4: v = 64'h0000_0000_FFFF_FFFF;
                    5: v = 64'h8000_0000_0000_0000;
                    6: v = 64'hFFFF_FFFF_0000_0000;
                    default: v = 64'h0000_0000_0000_07FF;
                endcase
            end
        endcase
        return v;
    endfunction

    task automatic test_random();
        bit to, lat, post; int bub, wc, d;
        logic [63:0] v;
        logic [4:0]  rd;
        for (int t = 0; t < 80; t++) begin
            v  = rand_value();
            rd = (t % 16 == 7) ? 5'd0 : 5'($urandom_range(31));
            build_expected(v, rd);
            do_txn(v, rd, int'($urandom_range(50)), to, lat, post, bub, wc);
            $display("txn rnd%0d v=%h rd=%0d n=%0d", t, v, rd, got_q.size());
            n_cmp++; if (to) begin n_bad++; $display("FAIL rnd_timeout: txn %0d got no last handshake, want completion", t); end
            n_cmp++; if (lat !== 1'b1) begin n_bad++; $display("FAIL rnd_latency: txn %0d out_valid %b after accept, want 1", t, lat); end
            d = diff_idx();
            n_cmp++; if (d >= 0) begin n_bad++; $display("FAIL rnd_seq: txn %0d instr %0d got %h want %h (len %0d vs %0d)", t, d, got_at(d), exp_at(d), got_q.size(), exp_q.size()); end
            if (rd != 5'd0) begin
                n_cmp++; if (run_isa(rd) !== v) begin n_bad++; $display("FAIL rnd_isa: txn %0d x%0d got %h want %h", t, rd, run_isa(rd), v); end
            end
            n_cmp++; if (post !== 1'b1) begin n_bad++; $display("FAIL rnd_post: txn %0d idle-after-last %b, want 1", t, post); end
        end
    endtask

    task automatic test_stall();
        logic [63:0] v;
        logic [31:0] snap_i;
        logic        snap_l, snap_v;
        bit          done;
        int          cyc, d;
        v = 64'h1234_5678_9ABC_DEF0;
        build_expected(v, 5'd7);
        got_q.delete();
        bus.req_valid = 1'b1; bus.req_value = v; bus.req_rd = 5'd7;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) begin
            if (bus.out_valid) got_q.push_back(bus.out_inst);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        snap_i = bus.out_inst; snap_l = bus.out_last; snap_v = bus.out_valid;
        n_cmp++; if (snap_v !== 1'b1) begin n_bad++; $display("FAIL stall_mid_valid: out_valid got %b want 1", snap_v); end
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin bus.req_valid = 1'b1; bus.req_value = 64'h5; bus.req_rd = 5'd3; end
            else bus.req_valid = 1'b0;
            @(posedge clk); #1;
            n_cmp++;
            if (bus.out_inst !== snap_i || bus.out_last !== snap_l || bus.out_valid !== snap_v || bus.req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold: cycle %0d got inst %h last %b valid %b ready %b, want %h %b %b 0",
                         c, bus.out_inst, bus.out_last, bus.out_valid, bus.req_ready, snap_i, snap_l, snap_v);
            end
        end
        bus.req_valid = 1'b0;
        done = 0; cyc = 0;
        bus.out_ready = 1'b1;
        while (!done && cyc < 50) begin
            if (bus.out_valid) begin got_q.push_back(bus.out_inst); done = bus.out_last; end
            @(posedge clk); #1; cyc++;
        end
        bus.out_ready = 1'b0;
        $display("txn stall v=%h rd=7 n=%0d", v, got_q.size());
        d = diff_idx();
        n_cmp++; if (!done || d >= 0) begin n_bad++; $display("FAIL stall_seq: done %b instr %0d got %h want %h", done, d, got_at(d), exp_at(d)); end
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL stall_no_phantom: valid %b ready %b, want 0 1", bus.out_valid, bus.req_ready); end
    endtask

    task automatic test_rst_mid();
        bit to, lat, post; int bub, wc;
        bus.req_valid = 1'b1; bus.req_value = 64'hFEDC_BA98_7654_3210; bus.req_rd = 5'd9;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", bus.req_ready); end
        do_txn(64'h0123_4567_89AB_CDEF, 5'd0, 0, to, lat, post, bub, wc);
        $display("txn rst_then_rd0 n=%0d", got_q.size());
        n_cmp++; if (to || got_q.size() != 1 || got_at(0) !== 32'h00000013) begin n_bad++; $display("FAIL rd0_nop: timeout %b got %0d instrs first %h, want 1 instr 00000013", to, got_q.size(), got_at(0)); end
    endtask

    task automatic test_back_to_back();
        bit to, lat, post; int bub, wc, d;
        logic [63:0] v;
        for (int t = 0; t < 6; t++) begin
            v = (t % 2 == 0) ? {$urandom, $urandom} : rand_value();
            build_expected(v, 5'd31);
            do_txn(v, 5'd31, 0, to, lat, post, bub, wc);
            $display("txn b2b%0d v=%h rd=31 n=%0d", t, v, got_q.size());
            d = diff_idx();
            n_cmp++; if (to || d >= 0) begin n_bad++; $display("FAIL b2b_seq: txn %0d instr %0d got %h want %h", t, d, got_at(d), exp_at(d)); end
            n_cmp++; if (bub != 0 || wc != 0) begin n_bad++; $display("FAIL b2b_rate: txn %0d bubbles %0d accept wait %0d, want 0 0", t, bub, wc); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_value = 64'd0; bus.req_rd = 5'd0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_rst_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
